// File: rtl/vitals_frame_rx_if.sv
// ============================================================================
// Module   : vitals_frame_rx_if
// Brief    : Serial byte input and parsed vitals output bundle for vitals_frame_rx.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vitals_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] age_category;
    logic [7:0] ecgin;
    logic [7:0] tempin;
    logic [7:0] spo2in;
    logic [7:0] sleepin;
    logic       frame_valid;
    logic       have_data;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_count;
    logic [7:0] err_count;

    // Sensor side: supplies bytes and observes the parsed sample.
    modport master (
        output rx_data, rx_valid,
        input  age_category, ecgin, tempin, spo2in, sleepin,
        input  frame_valid, have_data, frame_err, err_code, frame_count, err_count
    );

    // Receiver side.
    modport slave (
        input  rx_data, rx_valid,
        output age_category, ecgin, tempin, spo2in, sleepin,
        output frame_valid, have_data, frame_err, err_code, frame_count, err_count
    );
endinterface

`default_nettype wire

// File: rtl/vitals_frame_rx.sv
// ============================================================================
// Module   : vitals_frame_rx
// Brief    : Framed, checksummed vitals byte-stream receiver feeding the classifier.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vitals_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vitals_frame_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_HUNT  = 3'd0,
        S_HDR   = 3'd1,
        S_ECG   = 3'd2,
        S_TEMP  = 3'd3,
        S_SPO2  = 3'd4,
        S_SLEEP = 3'd5,
        S_CSUM  = 3'd6
    } state_t;

    localparam logic [1:0]  c_err_csum  = 2'b01;
    localparam logic [1:0]  c_err_hdr   = 2'b10;
    localparam logic [1:0]  c_err_tmo   = 2'b11;
    localparam logic [16:0] c_tmo_limit = 17'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] tmo_q, tmo_d;

    logic [1:0]  sh_age_q, sh_age_d;
    logic [7:0]  sh_ecg_q, sh_ecg_d;
    logic [7:0]  sh_temp_q, sh_temp_d;
    logic [7:0]  sh_spo2_q, sh_spo2_d;
    logic [7:0]  sh_sleep_q, sh_sleep_d;

    logic [1:0]  age_q, age_d;
    logic [7:0]  ecg_q, ecg_d;
    logic [7:0]  temp_q, temp_d;
    logic [7:0]  spo2_q, spo2_d;
    logic [7:0]  sleep_q, sleep_d;
    logic        fv_q, fv_d;
    logic        have_q, have_d;
    logic        fe_q, fe_d;
    logic [1:0]  ec_q, ec_d;
    logic [7:0]  fc_q, fc_d;
    logic [7:0]  errc_q, errc_d;

    logic        w_drop;
    logic [1:0]  w_drop_code;
    logic        w_tmo_hit;

    // Compared one bit wider so TIMEOUT_CYCLES=65535 is reachable without wrap.
    assign w_tmo_hit = (({1'b0, tmo_q} + 17'd1) == c_tmo_limit);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        sh_age_d    = sh_age_q;
        sh_ecg_d    = sh_ecg_q;
        sh_temp_d   = sh_temp_q;
        sh_spo2_d   = sh_spo2_q;
        sh_sleep_d  = sh_sleep_q;
        age_d       = age_q;
        ecg_d       = ecg_q;
        temp_d      = temp_q;
        spo2_d      = spo2_q;
        sleep_d     = sleep_q;
        fv_d        = 1'b0;
        have_d      = have_q;
        fe_d        = 1'b0;
        ec_d        = ec_q;
        fc_d        = fc_q;
        errc_d      = errc_q;
        w_drop      = 1'b0;
        w_drop_code = 2'b00;

        if (state_q == S_HUNT || bus.rx_valid) begin
            tmo_d = '0;
        end else if (w_tmo_hit) begin
            w_drop      = 1'b1;
            w_drop_code = c_err_tmo;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        if (bus.rx_valid) begin
            unique case (state_q)
                S_HUNT: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    if (bus.rx_data[7:2] != 6'd0) begin
                        w_drop      = 1'b1;
                        w_drop_code = c_err_hdr;
                    end else begin
                        sh_age_d = bus.rx_data[1:0];
                        sum_d    = bus.rx_data;
                        state_d  = S_ECG;
                    end
                end
                S_ECG: begin
                    sh_ecg_d = bus.rx_data;
                    sum_d    = sum_q + bus.rx_data;
                    state_d  = S_TEMP;
                end
                S_TEMP: begin
                    sh_temp_d = bus.rx_data;
                    sum_d     = sum_q + bus.rx_data;
                    state_d   = S_SPO2;
                end
                S_SPO2: begin
                    sh_spo2_d = bus.rx_data;
                    sum_d     = sum_q + bus.rx_data;
                    state_d   = S_SLEEP;
                end
                S_SLEEP: begin
                    sh_sleep_d = bus.rx_data;
                    sum_d      = sum_q + bus.rx_data;
                    state_d    = S_CSUM;
                end
                S_CSUM: begin
                    if (bus.rx_data == sum_q) begin
                        age_d   = sh_age_q;
                        ecg_d   = sh_ecg_q;
                        temp_d  = sh_temp_q;
                        spo2_d  = sh_spo2_q;
                        sleep_d = sh_sleep_q;
                        fv_d    = 1'b1;
                        have_d  = 1'b1;
                        fc_d    = fc_q + 8'd1;
                        state_d = S_HUNT;
                    end else begin
                        w_drop      = 1'b1;
                        w_drop_code = c_err_csum;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end

        if (w_drop) begin
            state_d = S_HUNT;
            tmo_d   = '0;
            fe_d    = 1'b1;
            ec_d    = w_drop_code;
            if (errc_q != 8'hFF) begin
                errc_d = errc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            sum_q      <= '0;
            tmo_q      <= '0;
            sh_age_q   <= '0;
            sh_ecg_q   <= '0;
            sh_temp_q  <= '0;
            sh_spo2_q  <= '0;
            sh_sleep_q <= '0;
            age_q      <= '0;
            ecg_q      <= '0;
            temp_q     <= '0;
            spo2_q     <= '0;
            sleep_q    <= '0;
            fv_q       <= 1'b0;
            have_q     <= 1'b0;
            fe_q       <= 1'b0;
            ec_q       <= '0;
            fc_q       <= '0;
            errc_q     <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            sh_age_q   <= sh_age_d;
            sh_ecg_q   <= sh_ecg_d;
            sh_temp_q  <= sh_temp_d;
            sh_spo2_q  <= sh_spo2_d;
            sh_sleep_q <= sh_sleep_d;
            age_q      <= age_d;
            ecg_q      <= ecg_d;
            temp_q     <= temp_d;
            spo2_q     <= spo2_d;
            sleep_q    <= sleep_d;
            fv_q       <= fv_d;
            have_q     <= have_d;
            fe_q       <= fe_d;
            ec_q       <= ec_d;
            fc_q       <= fc_d;
            errc_q     <= errc_d;
        end
    end

    assign bus.age_category = age_q;
    assign bus.ecgin        = ecg_q;
    assign bus.tempin       = temp_q;
    assign bus.spo2in       = spo2_q;
    assign bus.sleepin      = sleep_q;
    assign bus.frame_valid  = fv_q;
    assign bus.have_data    = have_q;
    assign bus.frame_err    = fe_q;
    assign bus.err_code     = ec_q;
    assign bus.frame_count  = fc_q;
    assign bus.err_count    = errc_q;

endmodule

`default_nettype wire

// File: tb/tb_vitals_frame_rx.sv
// ============================================================================
// Module   : tb_vitals_frame_rx
// Brief    : Self-checking bench for vitals_frame_rx against a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vitals_frame_rx;

    localparam logic [7:0] c_sync = 8'hA5;
    localparam int         c_tmo  = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   fv_pulses;

    vitals_frame_rx_if bus();

    vitals_frame_rx #(
        .SYNC_BYTE      (c_sync),
        .TIMEOUT_CYCLES (c_tmo)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: bytes collected since the sync byte, plus the expected output set.
    logic [7:0] m_frame[$];
    int         m_idle;
    logic [1:0] m_age;
    logic [7:0] m_ecg, m_temp, m_spo2, m_sleep;
    logic       m_fv, m_fe, m_have;
    logic [1:0] m_ec;
    int         m_fc, m_errc;
    logic [7:0] fb[7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_idle = 0;
        m_age = '0; m_ecg = '0; m_temp = '0; m_spo2 = '0; m_sleep = '0;
        m_fv = 1'b0; m_fe = 1'b0; m_have = 1'b0; m_ec = '0;
        m_fc = 0; m_errc = 0;
    endtask

    task automatic model_drop(input logic [1:0] code);
        m_fe = 1'b1;
        m_ec = code;
        if (m_errc < 255) m_errc++;
        m_frame.delete();
        m_idle = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d);
        int s;
        if (r) begin
            model_reset();
            return;
        end
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (m_frame.size() == 0) begin
            if (v && d == c_sync) m_frame.push_back(d);
        end else if (v) begin
            m_idle = 0;
            m_frame.push_back(d);
            if (m_frame.size() == 2 && d[7:2] != 6'd0) begin
                model_drop(2'b10);
            end else if (m_frame.size() == 7) begin
                s = int'(m_frame[1]) + int'(m_frame[2]) + int'(m_frame[3])
                  + int'(m_frame[4]) + int'(m_frame[5]);
                if ((s % 256) == int'(m_frame[6])) begin
                    m_age   = m_frame[1][1:0];
                    m_ecg   = m_frame[2];
                    m_temp  = m_frame[3];
                    m_spo2  = m_frame[4];
                    m_sleep = m_frame[5];
                    m_fv    = 1'b1;
                    m_have  = 1'b1;
                    m_fc    = (m_fc + 1) % 256;
                    m_frame.delete();
                end else begin
                    model_drop(2'b01);
                end
            end
        end else begin
            m_idle++;
            if (m_idle == c_tmo) model_drop(2'b11);
        end
    endtask

    task automatic check_all();
        chk("age",   32'(bus.age_category), 32'(m_age));
        chk("ecg",   32'(bus.ecgin),        32'(m_ecg));
        chk("temp",  32'(bus.tempin),       32'(m_temp));
        chk("spo2",  32'(bus.spo2in),       32'(m_spo2));
        chk("sleep", 32'(bus.sleepin),      32'(m_sleep));
        chk("fv",    32'(bus.frame_valid),  32'(m_fv));
        chk("fe",    32'(bus.frame_err),    32'(m_fe));
        chk("have",  32'(bus.have_data),    32'(m_have));
        chk("ecode", 32'(bus.err_code),     32'(m_ec));
        chk("fcnt",  32'(bus.frame_count),  32'(m_fc));
        chk("ecnt",  32'(bus.err_count),    32'(m_errc));
        chk("excl",  32'(bus.frame_valid & bus.frame_err), 32'd0);
    endtask

    // One clock: check what the previous edge produced, then drive the next inputs.
    task automatic step(input bit r, input bit v, input logic [7:0] d);
        @(negedge clk);
        check_all();
        if (bus.frame_valid === 1'b1) fv_pulses++;
        rst          = r;
        bus.rx_valid = v;
        bus.rx_data  = v ? d : 8'h00;
        model_step(r, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_fb(input int maxgap);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, fb[i]);
            if (maxgap > 0 && i < 6) idle($urandom_range(0, maxgap));
        end
    endtask

    // kind: 0 good, 1 bad checksum, 2 bad header
    task automatic build_frame(input int kind);
        logic [7:0] s;
        fb[0] = c_sync;
        fb[1] = {6'd0, 2'($urandom_range(0, 3))};
        if (kind == 2) fb[1][7:2] = 6'($urandom_range(1, 63));
        for (int i = 2; i < 6; i++) fb[i] = 8'($urandom);
        s = fb[1] + fb[2] + fb[3] + fb[4] + fb[5];
        fb[6] = (kind == 1) ? (s ^ 8'($urandom_range(1, 255))) : s;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fv_pulses = 0;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        model_reset();

        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        fb = '{8'hA5, 8'h02, 8'h4B, 8'h62, 8'h5F, 8'h08, 8'h16};
        send_fb(0);
        step(1'b0, 1'b0, 8'h00);
        chk("t1_fv",    32'(bus.frame_valid), 32'd1);
        chk("t1_age",   32'(bus.age_category), 32'd2);
        chk("t1_ecg",   32'(bus.ecgin), 32'd75);
        chk("t1_temp",  32'(bus.tempin), 32'd98);
        chk("t1_spo2",  32'(bus.spo2in), 32'd95);
        chk("t1_sleep", 32'(bus.sleepin), 32'd8);
        chk("t1_have",  32'(bus.have_data), 32'd1);
        chk("t1_fcnt",  32'(bus.frame_count), 32'd1);

        fb = '{8'hA5, 8'h00, 8'h78, 8'h62, 8'h60, 8'h0E, 8'h49};
        send_fb(0);
        step(1'b0, 1'b0, 8'h00);
        chk("t2_fe",   32'(bus.frame_err), 32'd1);
        chk("t2_code", 32'(bus.err_code), 32'd1);
        chk("t2_ecg",  32'(bus.ecgin), 32'd75);
        chk("t2_ecnt", 32'(bus.err_count), 32'd1);

        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        chk("t3_code", 32'(bus.err_code), 32'd2);
        chk("t3_ecnt", 32'(bus.err_count), 32'd2);
        fb = '{8'hA5, 8'h00, 8'h78, 8'h62, 8'h60, 8'h0E, 8'h48};
        send_fb(0);
        step(1'b0, 1'b0, 8'h00);
        chk("t3_ecg", 32'(bus.ecgin), 32'd120);
        chk("t3_age", 32'(bus.age_category), 32'd0);

        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h01);
        idle(3);
        step(1'b0, 1'b1, 8'h4C);
        idle(4);
        step(1'b0, 1'b0, 8'h00);
        chk("t4_fe",   32'(bus.frame_err), 32'd1);
        chk("t4_code", 32'(bus.err_code), 32'd3);
        chk("t4_ecnt", 32'(bus.err_count), 32'd3);

        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        fv_pulses = 0;
        for (int k = 0; k < 256; k++) begin
            build_frame(0);
            send_fb(0);
        end
        step(1'b0, 1'b0, 8'h00);
        chk("t5_fcnt",   32'(bus.frame_count), 32'd0);
        chk("t5_pulses", 32'(fv_pulses), 32'd256);
        for (int k = 0; k < 300; k++) begin
            build_frame(1);
            send_fb(0);
        end
        step(1'b0, 1'b0, 8'h00);
        chk("t5_ecnt", 32'(bus.err_count), 32'd255);

        fb = '{8'hA5, 8'h01, 8'h50, 8'h61, 8'h5E, 8'h07, 8'h17};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, fb[i]);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("t6_ecg",  32'(bus.ecgin), 32'd0);
        chk("t6_fcnt", 32'(bus.frame_count), 32'd0);
        chk("t6_ecnt", 32'(bus.err_count), 32'd0);
        chk("t6_have", 32'(bus.have_data), 32'd0);
        for (int i = 4; i < 7; i++) step(1'b0, 1'b1, fb[i]);
        send_fb(0);
        step(1'b0, 1'b0, 8'h00);
        chk("t6_ecg2",  32'(bus.ecgin), 32'd80);
        chk("t6_fcnt2", 32'(bus.frame_count), 32'd1);

        for (int k = 0; k < 400; k++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind == 3) begin
                for (int j = 0; j < $urandom_range(1, 4); j++)
                    step(1'b0, 1'b1, 8'($urandom));
            end else begin
                build_frame(kind > 2 ? 0 : kind);
                send_fb(kind == 4 ? c_tmo + 2 : (kind == 5 ? c_tmo - 1 : 0));
            end
            idle($urandom_range(0, 3));
        end
        idle(c_tmo + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vitals_frame_rx.md
# vitals_frame_rx

Receives the serial vitals byte stream from the sensor front-end and assembles framed, checksum-protected samples into the parallel bus that feeds the `wmd` threshold classifier: `age_category`, `ecgin`, `tempin`, `spo2in` and `sleepin`. Outputs are registered and change only when a complete, valid frame arrives, so `wmd` always sees a coherent sample set. The block also reports framing errors for the alert and logging path.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1000, allowed inter-byte gap mid-frame, in clock cycles (range 1..65535)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid this cycle; one byte is accepted per cycle
- age_category  out  2  last good frame: age category
- ecgin  out  8  last good frame: ECG/heart rate
- tempin  out  8  last good frame: temperature
- spo2in  out  8  last good frame: SpO2
- sleepin  out  8  last good frame: sleep hours
- frame_valid  out  1  one-cycle pulse when the outputs above have just updated
- have_data  out  1  level; 1 once any good frame has been received since reset
- frame_err  out  1  one-cycle pulse when a frame is dropped
- err_code  out  2  cause of the last error: 01 checksum, 10 header, 11 timeout; holds until the next error
- frame_count  out  8  count of good frames; wraps 255 to 0
- err_count  out  8  count of dropped frames; saturates at 255

## Operation
- Frame format, 7 bytes: SYNC_BYTE, HDR, ECG, TEMP, SPO2, SLEEP, CSUM.
  - HDR[7:2] must be 0. HDR[1:0] is the age category.
  - CSUM = (HDR + ECG + TEMP + SPO2 + SLEEP) mod 256, using an 8-bit wrapping sum.
- FSM states: HUNT, HDR, ECG, TEMP, SPO2, SLEEP, CSUM. Each accepted byte advances the state by one.
- HUNT:
  - A byte equal to SYNC_BYTE moves the FSM to HDR.
  - Any other byte is discarded silently, with no error.
- HDR:
  - If HDR[7:2] is nonzero, the frame is dropped with err_code=10 and the FSM returns to HUNT.
  - A SYNC_BYTE arriving here is treated as a header byte. 0xA5 has nonzero reserved bits, so it raises a header error.
- Payload bytes (ECG, TEMP, SPO2, SLEEP) go into shadow registers. The running sum is accumulated in an 8-bit register.
- CSUM:
  - On a match: copy the shadow registers to the outputs, pulse frame_valid, set have_data, increment frame_count, then return to HUNT.
  - On a mismatch: leave the outputs unchanged, drop the frame with err_code=01, and return to HUNT.
- Timeout:
  - In any state other than HUNT, a 16-bit counter counts cycles with rx_valid=0. It clears on every accepted byte.
  - When the count reaches TIMEOUT_CYCLES, the frame is dropped with err_code=11 and the FSM returns to HUNT.
  - The counter is idle and held at 0 while in HUNT.
- Every drop pulses frame_err and increments err_count, saturating at 255.
- Outputs never show a partial or bad frame. They hold the last good frame indefinitely.

## Timing
- Reset values: FSM in HUNT; every output 0, including age_category, all vitals, both pulses, have_data, err_code, both counters, the sum register and the timeout counter.
- Reset mid-frame discards the partial frame. The first byte after reset is parsed in HUNT.
- Latency: the edge that samples a correct CSUM byte loads the outputs and sets frame_valid. Both are visible in the next cycle, one cycle after the CSUM byte is presented. frame_valid clears on the following edge.
- frame_err and err_code follow the same rule: they update on the edge that samples the offending byte, or on the edge where the timeout count is reached.
- Back-to-back frames with no gap are supported: a SYNC byte in the cycle immediately after CSUM is accepted.
- Timeout versus byte in the same cycle: a cycle with rx_valid=1 is never counted, so the byte wins.
- Timeout expires exactly TIMEOUT_CYCLES consecutive invalid cycles after the last accepted byte.
- frame_valid and frame_err never assert in the same cycle.

## Test plan
- Reset, then frame A5 02 4B 62 5F 08 16 → next cycle: frame_valid=1, age=2, ecgin=75, tempin=98, spo2in=95, sleepin=8, have_data=1, frame_count=1.
- Frame A5 00 78 62 60 0E 49 (bad CSUM; correct is 48) → frame_err=1, err_code=01, outputs still hold the previous frame, err_count=1.
- Garbage 11 22 A5 A5 → no error on 11 or 22; the second A5 is taken as a header, giving err_code=10. Then a valid frame A5 00 78 62 60 0E 48 → ecgin=120, age=0.
- TIMEOUT_CYCLES=4: send A5 01, then rx_valid=0 for 3 cycles → no error. Then send 1 byte and idle 4 cycles → err_code=11 on the 4th idle cycle.
- 256 back-to-back valid frames → frame_count wraps to 0 and frame_valid pulses 256 times. Then 300 bad-CSUM frames → err_count stays at 255.
- Assert rst after the TEMP byte of a frame → all outputs 0. The remaining bytes are ignored in HUNT, and the next full frame is received correctly.
